// File: rtl/rvtu_valid_ctrl.sv
// Sequencing controller for the single port of the RVTU 128-entry valid-bit array.
// Optional occupancy counter is built when RVTU_VALID_CTRL_COUNT_EN is defined.
module rvtu_valid_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [6:0] req_addr,
    output logic       resp_valid,
    output logic       resp_hit,
    input  logic       flush_start,
    output logic       flush_busy,
    output logic       flush_done,
    output logic [6:0] arr_addr,
    output logic       arr_wdata,
    output logic       arr_wen,
    input  logic       arr_rdata
`ifdef RVTU_VALID_CTRL_COUNT_EN
    ,
    output logic [7:0] valid_count
`endif
);

    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [6:0] LAST_IDX = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RMW   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t     state_r, state_s;
    logic       pend_r, pend_s;
    logic [6:0] addr_r, addr_s;
    logic       set_r, set_s;
    logic [6:0] cnt_r, cnt_s;
    logic       done_r, done_s;

    // Next-state and port-side outputs; array address is combinational so the
    // registered-address array returns data in the following cycle.
    always_comb begin
        state_s    = state_r;
        pend_s     = 1'b0;
        addr_s     = addr_r;
        set_s      = set_r;
        cnt_s      = cnt_r;
        done_s     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = pend_r;
        resp_hit   = pend_r & arr_rdata;
        flush_busy = 1'b0;
        flush_done = done_r;
        arr_addr   = 7'd0;
        arr_wdata  = 1'b0;
        arr_wen    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (flush_start) begin
                    state_s = ST_FLUSH;
                    cnt_s   = 7'd0;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        arr_addr = req_addr;
                        if ((req_op == OP_SET) || (req_op == OP_CLR)) begin
                            addr_s  = req_addr;
                            set_s   = (req_op == OP_SET);
                            state_s = ST_RMW;
                        end else begin
                            pend_s = 1'b1;
                        end
                    end else begin
                        arr_addr = 7'd0;
                    end
                end
            end
            ST_RMW: begin
                arr_addr   = addr_r;
                arr_wen    = 1'b1;
                arr_wdata  = set_r;
                resp_valid = 1'b1;
                resp_hit   = arr_rdata;
                state_s    = ST_IDLE;
            end
            ST_FLUSH: begin
                flush_busy = 1'b1;
                arr_wen    = 1'b1;
                arr_addr   = cnt_r;
                if (cnt_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    cnt_s   = 7'd0;
                end else begin
                    cnt_s = cnt_r + 7'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs read as reset values for as long as rst is held.
        if (rst) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_hit   = 1'b0;
            flush_busy = 1'b0;
            flush_done = 1'b0;
            arr_addr   = 7'd0;
            arr_wdata  = 1'b0;
            arr_wen    = 1'b0;
        end else begin
            flush_done = done_r;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pend_r  <= 1'b0;
            addr_r  <= 7'd0;
            set_r   <= 1'b0;
            cnt_r   <= 7'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
            addr_r  <= addr_s;
            set_r   <= set_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

`ifdef RVTU_VALID_CTRL_COUNT_EN
    logic [7:0] count_r;

    // Occupancy tracks observed bit transitions; a completed flush empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (done_s) begin
            count_r <= 8'd0;
        end else if (state_r == ST_RMW) begin
            if (set_r && !arr_rdata && (count_r < 8'd128)) begin
                count_r <= count_r + 8'd1;
            end else if (!set_r && arr_rdata && (count_r != 8'd0)) begin
                count_r <= count_r - 8'd1;
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign valid_count = count_r;
`endif

endmodule
